// File: rtl/lcd_write_queue_if.sv
// Upstream entry handshake for the LCD write queue.
// valid/ready: an entry {in_rs, in_data} transfers on a rising clk edge where in_valid && in_ready; the master holds it stable until then.
interface lcd_write_queue_if;
  logic       in_valid;
  logic       in_ready;
  logic       in_rs;
  logic [7:0] in_data;

  modport master (output in_valid, output in_rs, output in_data, input in_ready);
  modport slave  (input in_valid, input in_rs, input in_data, output in_ready);
endinterface

// File: rtl/lcd_write_queue.sv
// Buffered HD44780 write engine: FIFO of {rs, data} entries, each replayed as
// setup / e pulse / hold / execution wait on the LCD pins.
module lcd_write_queue #(
  parameter int DEPTH        = 16,
  parameter int T_SETUP      = 2,
  parameter int T_PULSE      = 12,
  parameter int T_HOLD       = 2,
  parameter int T_WAIT_CHAR  = 2000,
  parameter int T_WAIT_CLEAR = 82000
) (
  input  logic                    clk,
  input  logic                    reset,
  lcd_write_queue_if.slave        up,
  output logic                    lcd_e,
  output logic                    lcd_rs,
  output logic                    lcd_rw,
  output logic [7:0]              lcd_data,
  output logic                    busy,
  output logic [$clog2(DEPTH):0]  fifo_count,
  output logic [2:0]              dbg_state
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = 20;
  localparam logic [AW:0]   FULL      = (AW+1)'(DEPTH);
  localparam logic [CW-1:0] LD_SETUP  = CW'(T_SETUP - 1);
  localparam logic [CW-1:0] LD_PULSE  = CW'(T_PULSE - 1);
  localparam logic [CW-1:0] LD_HOLD   = CW'(T_HOLD - 1);
  localparam logic [CW-1:0] LD_CHAR   = CW'(T_WAIT_CHAR - 1);
  localparam logic [CW-1:0] LD_CLEAR  = CW'(T_WAIT_CLEAR - 1);

  typedef enum logic [2:0] {IDLE, SETUP, PULSE, HOLD, WAIT} state_e;

  state_e        state_q;
  logic [8:0]    mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [AW:0]   count_q, count_d;
  logic [CW-1:0] cnt_q;
  logic          clear_q;
  logic          lcd_e_q, lcd_rs_q;
  logic [7:0]    lcd_data_q;
  logic          push, pop, head_clear;
  logic [8:0]    head;

  assign up.in_ready = (count_q != FULL);
  assign push        = up.in_valid && up.in_ready;
  assign pop         = (state_q == IDLE) && (count_q != '0);
  assign head        = mem_q[rd_ptr_q];
  // Clear display (0x01) and return home (0x02/0x03) need the long execution wait.
  assign head_clear  = !head[8] && (head[7:2] == 6'd0) && (head[1:0] != 2'd0);

  always_comb begin
    count_d = count_q;
    if (push && !pop)      count_d = count_q + 1'b1;
    else if (!push && pop) count_d = count_q - 1'b1;
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= {up.in_rs, up.in_data};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q <= count_d;
    end
  end

  // Every phase loads cnt_q with its length minus one and advances when it reaches zero.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      clear_q    <= 1'b0;
      lcd_e_q    <= 1'b0;
      lcd_rs_q   <= 1'b0;
      lcd_data_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (pop) begin
            lcd_rs_q   <= head[8];
            lcd_data_q <= head[7:0];
            clear_q    <= head_clear;
            cnt_q      <= LD_SETUP;
            state_q    <= SETUP;
          end
        end
        SETUP: begin
          if (cnt_q == '0) begin
            lcd_e_q <= 1'b1;
            cnt_q   <= LD_PULSE;
            state_q <= PULSE;
          end else cnt_q <= cnt_q - 1'b1;
        end
        PULSE: begin
          if (cnt_q == '0) begin
            lcd_e_q <= 1'b0;
            cnt_q   <= LD_HOLD;
            state_q <= HOLD;
          end else cnt_q <= cnt_q - 1'b1;
        end
        HOLD: begin
          if (cnt_q == '0) begin
            cnt_q   <= clear_q ? LD_CLEAR : LD_CHAR;
            state_q <= WAIT;
          end else cnt_q <= cnt_q - 1'b1;
        end
        WAIT: begin
          if (cnt_q == '0) state_q <= IDLE;
          else             cnt_q   <= cnt_q - 1'b1;
        end
        default: begin
          lcd_e_q <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign lcd_e      = lcd_e_q;
  assign lcd_rs     = lcd_rs_q;
  assign lcd_rw     = 1'b0;
  assign lcd_data   = lcd_data_q;
  assign busy       = (state_q != IDLE) || (count_q != '0);
  assign fifo_count = count_q;
  assign dbg_state  = state_q;
endmodule

// File: doc/lcd_write_queue.md
Name: lcd_write_queue

Overview:
- Buffered write engine between the LCD sequencer logic and the HD44780-style character LCD pins.
- Upstream logic pushes (rs, data) entries through a valid/ready handshake into a small FIFO.
- The block pops each entry and drives one complete LCD write cycle: setup, e pulse, hold, then a command-dependent execution wait.
- Upstream logic no longer has to derive e from a divided clock or hand-tune per-state delays.

Parameters:
- DEPTH, 16, FIFO entries; power of two, at least 2.
- T_SETUP, 2, clk cycles rs/data are stable with e low before the e pulse; at least 1.
- T_PULSE, 12, clk cycles e is held high; at least 1.
- T_HOLD, 2, clk cycles e is low with data held after the pulse; at least 1.
- T_WAIT_CHAR, 2000, wait cycles after a normal command or character; at least 1.
- T_WAIT_CLEAR, 82000, wait cycles after a clear-display or return-home command; at least 1; must be below 2^20.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- in_valid  in  1  upstream entry valid
- in_ready  out  1  FIFO can accept an entry
- in_rs  in  1  register select of the entry (0 = command, 1 = data)
- in_data  in  8  byte of the entry
- lcd_e  out  1  LCD enable strobe
- lcd_rs  out  1  LCD register select
- lcd_rw  out  1  LCD read/write; tied to write
- lcd_data  out  8  LCD data bus
- busy  out  1  FIFO non-empty or write cycle in progress
- fifo_count  out  $clog2(DEPTH)+1  current FIFO occupancy

Behaviour:
- Single clock domain. Reset is synchronous, active-high, sampled on rising clk.
- Reset values: lcd_e=0, lcd_rs=0, lcd_rw=0, lcd_data=0x00, busy=0, fifo_count=0, in_ready=1, state=IDLE, FIFO flushed.
- Reset mid-operation: everything returns to reset values on the next edge. lcd_e drops immediately and the in-flight write is abandoned.
- FIFO: 9-bit entries {rs, data}.
  - in_ready = (fifo_count != DEPTH), combinational from the count.
  - Push occurs when in_valid && in_ready at a rising edge.
  - in_valid while full is ignored; upstream holds the entry.
  - Push and pop on the same edge leave the count unchanged. Pointers wrap modulo DEPTH.
- lcd_rw is constant 0.
- FSM states: IDLE, SETUP, PULSE, HOLD, WAIT. One down-counter, at least 20 bits wide.
- IDLE:
  - If fifo_count>0: pop the head, load lcd_rs/lcd_data, select the wait length, go to SETUP. The counter loads T_SETUP-1.
  - If empty: stay in IDLE. lcd_rs/lcd_data keep their last values.
- SETUP: lcd_e=0 for exactly T_SETUP cycles, then PULSE.
- PULSE: lcd_e=1 for exactly T_PULSE cycles, then HOLD.
- HOLD: lcd_e=0 for T_HOLD cycles, then WAIT.
- WAIT: lcd_e=0 for the selected wait length, then IDLE.
- Wait selection:
  - rs=0 and data[7:2]==0 with data!=0 (clear 0x01, home 0x02/0x03) uses T_WAIT_CLEAR.
  - Every other entry uses T_WAIT_CHAR.
- lcd_rs and lcd_data change only on the IDLE pop edge. They are stable from SETUP through WAIT.
- lcd_e is registered and glitch-free.
- Latency:
  - Entry pushed at edge k into an empty FIFO with the FSM in IDLE: popped at edge k+1.
  - lcd_e rises at edge k+1+T_SETUP and falls at edge k+1+T_SETUP+T_PULSE.
- Throughput: one entry per T_SETUP+T_PULSE+T_HOLD+T_wait+1 cycles. The IDLE cycle is included in that count.
- busy = (state!=IDLE) || (fifo_count!=0), registered-equivalent with no glitches.

Test Plan (parameters DEPTH=4, T_SETUP=2, T_PULSE=4, T_HOLD=2, T_WAIT_CHAR=5, T_WAIT_CLEAR=20):
- Reset held 3 cycles, then released with in_valid=0 -> lcd_e=0, lcd_rs=0, lcd_data=0x00, lcd_rw=0, in_ready=1, busy=0, fifo_count=0.
- Single push rs=1, data=0x41 at edge 0 -> lcd_rs=1 and lcd_data=0x41 from edge 1; lcd_e high for edges 3..7 (4 cycles); busy falls after edge 14.
- Back-to-back pushes 0x48, 0x49 (rs=1) -> lcd_e rising edges exactly 14 cycles apart; data 0x49 first appears at the second pop edge.
- Push rs=0, data=0x01 then rs=1, data=0x41 -> lcd_e rising edges 29 cycles apart (clear wait). Repeat with 0x0C -> 14 cycles apart.
- Six consecutive pushes with in_valid held high -> first pops at edge 1; in_ready=0 after the 5th accepted push with fifo_count=4; the 6th is accepted on the edge after the next pop; all six bytes appear on lcd_data in order.
- Reset asserted during PULSE with 2 entries queued -> next edge: lcd_e=0, fifo_count=0, busy=0; no further e pulses without new pushes.
